// File: rtl/uart_host_master.sv
// uart_host_master
//   Host-side bus initiator for the UART register block. After reset it
//   programs the divisor latch, line control, FIFO control, interrupt enable
//   and modem control registers. It then loops: wait a few idle cycles, read
//   LS, and service at most one receive (RB read) or one transmit (TR write).
//   Receive-line error bits seen in LS are kept as sticky flags.
//
// Ports
//   clk, wb_rst_i          clock, asynchronous active-high reset
//   wb_addr_o/dat_o        register address and write data to the UART block
//   wb_we_o, wb_re_o       single-cycle write / read strobes (never together)
//   wb_dat_i               read data, valid the cycle after wb_re_o
//   tx_data/valid/ready    transmit byte stream (one-byte buffer)
//   rx_data/valid/ready    receive byte stream
//   init_done              configuration sequence finished
//   err_flags, err_clr     sticky {LS[7],LS[4],LS[3],LS[2],LS[1]} and clear
module uart_host_master #(
  parameter logic [15:0] DIVISOR  = 16'd27,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter logic [7:0]  FCR_VAL  = 8'hC6,
  parameter logic [7:0]  IER_VAL  = 8'h00,
  parameter logic [4:0]  MCR_VAL  = 5'h03,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  output logic [2:0] wb_addr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_re_o,
  input  logic [7:0] wb_dat_i,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic [4:0] err_flags,
  input  logic       err_clr
);

  localparam logic [2:0] ADDR_RB = 3'd0;
  localparam logic [2:0] ADDR_IE = 3'd1;
  localparam logic [2:0] ADDR_FC = 3'd2;
  localparam logic [2:0] ADDR_LC = 3'd3;
  localparam logic [2:0] ADDR_MC = 3'd4;
  localparam logic [2:0] ADDR_LS = 3'd5;
  localparam logic [3:0] GAP_LAST = 4'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_INIT, S_GAP, S_POLL, S_POLL_CAP, S_DECIDE, S_TX_WR, S_RX_RD, S_RX_CAP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  init_cnt_q, init_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        init_done_q, init_done_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  dat_q, dat_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [7:0]  lsr_q;
  logic [7:0]  tx_buf_q;
  logic        tx_full_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic [4:0]  err_q;
  logic [4:0]  err_set;

  // Bus outputs are registered: the comb block decides what the next cycle
  // drives, so the strobe is visible for exactly the cycle spent in the
  // corresponding state and nothing glitches out of the UART block's inputs.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      re_q        <= re_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    gap_cnt_d   = '0;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    case (state_q)
      S_INIT: begin
        // Seven back-to-back writes; DLAB is set by the first LC write and
        // dropped by the second, so RB/IE in between hit DL1/DL2.
        if (init_cnt_q == 3'd7) begin
          init_done_d = 1'b1;
          state_d     = S_GAP;
        end else begin
          we_d       = 1'b1;
          init_cnt_d = init_cnt_q + 3'd1;
          case (init_cnt_q)
            3'd0:    begin addr_d = ADDR_LC; dat_d = LCR_VAL | 8'h80; end
            3'd1:    begin addr_d = ADDR_RB; dat_d = DIVISOR[7:0];    end
            3'd2:    begin addr_d = ADDR_IE; dat_d = DIVISOR[15:8];   end
            3'd3:    begin addr_d = ADDR_LC; dat_d = LCR_VAL & 8'h7F; end
            3'd4:    begin addr_d = ADDR_FC; dat_d = FCR_VAL;         end
            3'd5:    begin addr_d = ADDR_IE; dat_d = IER_VAL;         end
            default: begin addr_d = ADDR_MC; dat_d = {3'b000, MCR_VAL}; end
          endcase
        end
      end
      S_GAP: begin
        // Idle spacing lets RB pops and LS status settle before the next poll.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_POLL;
          re_d    = 1'b1;
          addr_d  = ADDR_LS;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      S_POLL:     state_d = S_POLL_CAP;
      S_POLL_CAP: state_d = S_DECIDE;
      S_DECIDE: begin
        // Receive wins over transmit; an unaccepted rx byte blocks RB reads.
        if (lsr_q[0] && !rx_valid_q) begin
          state_d = S_RX_RD;
          re_d    = 1'b1;
          addr_d  = ADDR_RB;
        end else if (lsr_q[5] && tx_full_q) begin
          state_d = S_TX_WR;
          we_d    = 1'b1;
          addr_d  = ADDR_RB;
          dat_d   = tx_buf_q;
        end else begin
          state_d = S_GAP;
        end
      end
      S_TX_WR:  state_d = S_GAP;
      S_RX_RD:  state_d = S_RX_CAP;
      S_RX_CAP: state_d = S_GAP;
      default:  state_d = S_GAP;
    endcase
  end

  assign err_set = (state_q == S_POLL_CAP) ?
                   {wb_dat_i[7], wb_dat_i[4], wb_dat_i[3], wb_dat_i[2], wb_dat_i[1]} : 5'b0;

  // Datapath: LS capture, one-byte tx buffer, rx holding register and the
  // sticky error flags (new error bits win over a simultaneous clear).
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lsr_q      <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (state_q == S_POLL_CAP) begin
        lsr_q <= wb_dat_i;
      end
      if (tx_valid && tx_ready) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end else if (state_q == S_TX_WR) begin
        tx_full_q <= 1'b0;
      end
      if (state_q == S_RX_CAP) begin
        rx_data_q  <= wb_dat_i;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      err_q <= err_clr ? err_set : (err_q | err_set);
    end
  end

  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_re_o   = re_q;
  assign init_done = init_done_q;
  assign tx_ready  = ~tx_full_q & init_done_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_uart_host_master.sv
// Directed testbench for uart_host_master with a minimal UART register model
// that answers LS and RB reads one cycle after the read strobe.
module tb_uart_host_master;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dat_o;
  logic       wb_we_o;
  logic       wb_re_o;
  logic [7:0] wb_dat_i;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       init_done;
  logic [4:0] err_flags;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  // Register model state
  logic [7:0] lsVal;
  logic [7:0] rbVal;
  logic [2:0] lastAddr = 3'd0;

  // Monitor counters
  int trWrites = 0;
  int rbReads  = 0;
  int lsPolls  = 0;
  int overlap  = 0;

  uart_host_master dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .wb_addr_o (wb_addr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we_o),
    .wb_re_o   (wb_re_o),
    .wb_dat_i  (wb_dat_i),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .init_done (init_done),
    .err_flags (err_flags),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Read data appears the cycle after the strobe, selected by the latched address.
  always @(posedge clk) begin
    if (wb_re_o) lastAddr <= wb_addr_o;
  end
  assign wb_dat_i = (lastAddr == 3'd5) ? lsVal : ((lastAddr == 3'd0) ? rbVal : 8'h00);

  // Bus activity monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wb_re_o && wb_we_o) overlap++;
    if (wb_we_o && wb_addr_o == 3'd0 && init_done) trWrites++;
    if (wb_re_o && wb_addr_o == 3'd0) rbReads++;
    if (wb_re_o && wb_addr_o == 3'd5) lsPolls++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte on the tx stream for one cycle (called on a negedge).
  task automatic applyStimulus(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  logic [12:0] initExp [7];
  int n;
  int baseTr, baseRb, basePoll;
  int quiet;
  logic seen;

  initial begin
    initExp[0] = {1'b1, 1'b0, 3'd3, 8'h83};
    initExp[1] = {1'b1, 1'b0, 3'd0, 8'h1B};
    initExp[2] = {1'b1, 1'b0, 3'd1, 8'h00};
    initExp[3] = {1'b1, 1'b0, 3'd3, 8'h03};
    initExp[4] = {1'b1, 1'b0, 3'd2, 8'hC6};
    initExp[5] = {1'b1, 1'b0, 3'd1, 8'h00};
    initExp[6] = {1'b1, 1'b0, 3'd4, 8'h03};

    wb_rst_i = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    lsVal    = 8'h00;
    rbVal    = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_bus", {19'd0, wb_we_o, wb_re_o, wb_addr_o, wb_dat_o}, 32'd0);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_rx", {23'd0, rx_valid, rx_data}, 32'd0);
    checkOutput("rst_err", {27'd0, err_flags}, 32'd0);
    checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd0);

    // Configuration sequence, one write per cycle
    wb_rst_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("init_wr%0d", i),
                  {19'd0, wb_we_o, wb_re_o, wb_addr_o, wb_dat_o}, {19'd0, initExp[i]});
    end
    @(posedge clk); #1;
    checkOutput("init_done_c8", {31'd0, init_done}, 32'd1);
    checkOutput("init_we_low_c8", {31'd0, wb_we_o}, 32'd0);
    checkOutput("tx_ready_c8", {31'd0, tx_ready}, 32'd1);

    // Transmit one byte
    @(negedge clk);
    applyStimulus(8'h55);
    checkOutput("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    baseTr = trWrites;
    lsVal  = 8'h60;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = wb_we_o && (wb_addr_o == 3'd0);
    end
    checkOutput("tx_wr_seen", {31'd0, seen}, 32'd1);
    checkOutput("tx_wr_data", {24'd0, wb_dat_o}, 32'h55);
    @(negedge clk);
    checkOutput("tx_ready_after_wr", {31'd0, tx_ready}, 32'd1);
    repeat (40) @(negedge clk);
    checkOutput("tx_wr_count", trWrites - baseTr, 32'd1);

    // Receive one byte with immediate acceptance
    rbVal    = 8'hA5;
    rx_ready = 1'b1;
    baseRb   = rbReads;
    lsVal    = 8'h61;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = rx_valid;
    end
    lsVal = 8'h60;
    checkOutput("rx_valid_seen", {31'd0, seen}, 32'd1);
    checkOutput("rx_data_a5", {24'd0, rx_data}, 32'hA5);
    quiet = int'(wb_we_o | wb_re_o);
    @(negedge clk);
    checkOutput("rx_valid_pulse", {31'd0, rx_valid}, 32'd0);
    quiet += int'(wb_we_o | wb_re_o);
    repeat (2) begin
      @(negedge clk);
      quiet += int'(wb_we_o | wb_re_o);
    end
    checkOutput("rx_gap_quiet", quiet, 32'd0);
    @(negedge clk);
    checkOutput("rx_poll_resume", {28'd0, wb_re_o, wb_addr_o}, {28'd0, 1'b1, 3'd5});
    checkOutput("rx_rb_count", rbReads - baseRb, 32'd1);

    // Back-pressure: unaccepted byte blocks further RB reads
    repeat (10) @(negedge clk);
    rx_ready = 1'b0;
    rbVal    = 8'h3C;
    baseRb   = rbReads;
    basePoll = lsPolls;
    lsVal    = 8'h61;
    repeat (50) @(negedge clk);
    checkOutput("bp_rb_count", rbReads - baseRb, 32'd1);
    checkOutput("bp_polls_continue", {31'd0, (lsPolls - basePoll) >= 5}, 32'd1);
    checkOutput("bp_rx_hold", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h3C});
    lsVal    = 8'h60;
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_rx_accept", {31'd0, rx_valid}, 32'd0);

    // Sticky error flags
    repeat (10) @(negedge clk);
    lsVal = 8'h8B;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = wb_re_o && (wb_addr_o == 3'd5);
    end
    checkOutput("err_poll_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    lsVal = 8'h61;
    repeat (30) @(negedge clk);
    checkOutput("err_sticky", {27'd0, err_flags}, {27'd0, 5'b10101});
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_cleared", {27'd0, err_flags}, 32'd0);

    // Set beats clear when both land in the same cycle
    lsVal   = 8'h10;
    err_clr = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = wb_re_o && (wb_addr_o == 3'd5);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("err_set_priority", {27'd0, err_flags}, {27'd0, 5'b01000});
    lsVal = 8'h60;
    @(negedge clk);
    checkOutput("err_clr_next", {27'd0, err_flags}, 32'd0);
    err_clr = 1'b0;

    // Receive takes priority over a pending transmit
    lsVal = 8'h00;
    repeat (12) @(negedge clk);
    checkOutput("prio_tx_ready", {31'd0, tx_ready}, 32'd1);
    applyStimulus(8'h99);
    rbVal  = 8'h77;
    baseTr = trWrites;
    lsVal  = 8'h61;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = wb_re_o && (wb_addr_o == 3'd0);
    end
    lsVal = 8'h60;
    checkOutput("prio_rb_seen", {31'd0, seen}, 32'd1);
    checkOutput("prio_no_tr_first", trWrites - baseTr, 32'd0);
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = wb_we_o && (wb_addr_o == 3'd0);
    end
    checkOutput("prio_tr_seen", {31'd0, seen}, 32'd1);
    checkOutput("prio_tr_data", {24'd0, wb_dat_o}, 32'h99);
    checkOutput("no_strobe_overlap", overlap, 32'd0);

    // Reset in the middle of an access
    lsVal = 8'h61;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = wb_re_o;
    end
    checkOutput("mid_strobe_seen", {31'd0, seen}, 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_strobes", {30'd0, wb_we_o, wb_re_o}, 32'd0);
    checkOutput("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("restart_wr0", {19'd0, wb_we_o, wb_re_o, wb_addr_o, wb_dat_o},
                {19'd0, initExp[0]});
    checkOutput("restart_tx_ready", {31'd0, tx_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
